// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction fetch engine with an in-order prefetch queue, PC tracking and redirect flush
module if_prefetch_queue #(
    parameter int ADDR_SIZE = 32,
    parameter int INSTR_SIZE = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0]  instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [ADDR_SIZE-1:0]  pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d, out_q, out_d, kill_q, kill_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d, frd_q, frd_d, fwr_q, fwr_d;
    logic [INSTR_SIZE-1:0] ins_mem [DEPTH];
    logic [ADDR_SIZE-1:0]  ipc_mem [DEPTH];
    logic [ADDR_SIZE-1:0]  fpc_mem [DEPTH];
    logic                  room, accept, resp, push, pop;
    logic                  unused_ok;

    // Queued entries plus requests in flight may never exceed DEPTH, so every response has a slot.
    assign room        = ({1'b0, count_q} + {1'b0, out_q}) < DEPTH_C;
    assign imem_req    = ~reset & ~redirect & room;
    assign imem_addr   = pc_q;
    assign accept      = imem_req & imem_ready;
    assign resp        = imem_rvalid & (out_q != '0);
    assign push        = resp & (kill_q == '0) & ~redirect;
    assign instr_valid = count_q != '0;
    assign pop         = instr_valid & instr_ready;
    assign instr       = instr_valid ? ins_mem[rd_q] : '0;
    assign instr_pc    = instr_valid ? ipc_mem[rd_q] : '0;
    assign unused_ok   = ^redirect_pc[1:0];

    // Next state; a redirect flushes the queue and marks every still-unanswered request for discard.
    always_comb begin
        pc_d    = accept ? pc_q + ADDR_SIZE'(4) : pc_q;
        out_d   = out_q + CW'(accept) - CW'(resp);
        kill_d  = (resp && kill_q != '0) ? kill_q - CW'(1) : kill_q;
        count_d = count_q + CW'(push) - CW'(pop);
        rd_d    = pop ? rd_q + PW'(1) : rd_q;
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        fwr_d   = accept ? fwr_q + PW'(1) : fwr_q;
        frd_d   = resp ? frd_q + PW'(1) : frd_q;
        if (redirect) begin
            pc_d    = {redirect_pc[ADDR_SIZE-1:2], 2'b00};
            kill_d  = out_q - CW'(resp);
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            out_q   <= '0;
            kill_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            frd_q   <= '0;
            fwr_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            out_q   <= out_d;
            kill_q  <= kill_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            frd_q   <= frd_d;
            fwr_q   <= fwr_d;
        end
    end

    // Request PCs wait in their own FIFO and are paired with the instruction as it returns.
    always_ff @(posedge clk) begin
        if (accept) fpc_mem[fwr_q] <= pc_q;
        if (push) begin
            ins_mem[wr_q] <= imem_rdata;
            ipc_mem[wr_q] <= fpc_mem[frd_q];
        end
    end
endmodule
